mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the MIPS core. It sequences each instruction through FETCH/DECODE/EXE/MEM/WB/BR states. It produces the next-PC select and the single PC write strobe consumed by the next-PC unit and PC register, plus the IR, register-file, data-memory and datapath mux controls. PC is written exactly once per instruction, in that instruction's final state, with the next PC computed from the unmodified current PC.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]; valid from DECODE onward
- dm_rdy  in  1  data-memory ready; completes MEM state
- ir_we  out  1  IR load strobe
- pc_we  out  1  PC load strobe; also the instruction-retired pulse
- npc_sel  out  2  00 pc+4, 01 beq, 10 j/jal, 11 jr
- rf_we  out  1  register-file write strobe
- dm_we  out  1  data-memory write strobe
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- wd_sel  out  2  00 ALU, 01 memory, 10 pc+4
- alu_src  out  1  0 rt data, 1 extended imm
- alu_op  out  2  00 add, 01 sub, 10 or
- ext_op  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
- illegal  out  1  unsupported-instruction pulse
- state  out  3  current state, debug

## Operation
- State encoding: FETCH 0, DECODE 1, EXE 2, MEM 3, WB 4, BR 5. Codes 6–7 return to FETCH.
- Supported instructions:
  - addu: op 000000, funct 100001
  - subu: op 000000, funct 100011
  - jr: op 000000, funct 001000
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011
- Sequences (the state carrying pc_we is the instruction's last state):
  - addu, subu, ori, lui: FETCH→DECODE→EXE→WB; rf_we and pc_we in WB.
  - lw: FETCH→DECODE→EXE→MEM→WB; rf_we and pc_we in WB.
  - sw: FETCH→DECODE→EXE→MEM; dm_we in MEM; pc_we only in the cycle MEM exits.
  - beq: FETCH→DECODE→BR; pc_we in BR with npc_sel=01. The next-PC unit gates the branch with the ALU zero flag.
  - j: FETCH→DECODE; pc_we with npc_sel=10.
  - jal: FETCH→DECODE; pc_we with npc_sel=10, plus rf_we, reg_dst=10, wd_sel=10.
  - jr: FETCH→DECODE; pc_we with npc_sel=11.
  - Unsupported op/funct: FETCH→DECODE; pc_we with npc_sel=00 and illegal=1. The instruction is skipped as a nop.
- FETCH: ir_we=1 and no other strobe; always advances to DECODE.
- MEM: held while dm_rdy=0.
  - lw: advances to WB when dm_rdy=1.
  - sw: dm_we stays asserted throughout MEM; on dm_rdy=1, pc_we=1 and the next state is FETCH.
- Field controls (reg_dst, wd_sel, alu_src, alu_op, ext_op) are decoded purely from op/funct. They are driven from DECODE through the final state and are 0 in FETCH.
  - addu: reg_dst 01, alu_op 00
  - subu: reg_dst 01, alu_op 01
  - ori: alu_src 1, ext_op 00, alu_op 10
  - lui: alu_src 1, ext_op 10, alu_op 00 (rs=$0)
  - lw/sw: alu_src 1, ext_op 01, alu_op 00; lw adds wd_sel 01
  - beq: alu_src 0, alu_op 01
- npc_sel defaults to 00 whenever pc_we=0.

## Timing
- Reset: rst sampled high forces state to FETCH at that edge. While rst=1, all outputs are 0, including ir_we, and state reads as 0.
  - The first ir_we occurs in the first cycle with rst=0.
  - Reset mid-instruction aborts it; no pc_we or rf_we is issued in the reset cycle.
- All strobes are combinational from state and op/funct. They are single-cycle, except dm_we, which lasts the whole MEM dwell.
- CPI with dm_rdy tied high: j, jal, jr and illegal 2; beq 3; R-type, ori, lui and sw 4; lw 5.
- Each dm_rdy low cycle adds one cycle.
- Exactly one pc_we pulse per instruction. The cycle after pc_we is always FETCH.
- rf_we and pc_we may coincide (WB, jal). The register file and PC both update on that edge.

## Test plan
- Reset: hold rst 3 cycles mid-lw (in MEM) -> all outputs 0, state=0; first cycle after release has ir_we=1, and no pc_we occurs before the next WB.
- addu (op 0, funct 100001), dm_rdy=1 -> states 0,1,2,4; WB shows rf_we=1, reg_dst=01, wd_sel=00, pc_we=1, npc_sel=00; 4 cycles total.
- lw with dm_rdy low 2 cycles -> MEM held 3 cycles, then WB with wd_sel=01, rf_we=1, pc_we=1; 7 cycles total. Repeat for sw -> dm_we high for 3 cycles, pc_we only in the last of them, no rf_we.
- beq -> states 0,1,5; BR has alu_op=01, alu_src=0, pc_we=1, npc_sel=01; 3 cycles.
- jal then jr back-to-back -> jal DECODE: pc_we=1, npc_sel=10, rf_we=1, reg_dst=10, wd_sel=10. jr DECODE: pc_we=1, npc_sel=11, rf_we=0. 4 cycles total.
- op 111111 -> illegal=1 and pc_we=1 with npc_sel=00 in DECODE; no rf_we or dm_we; next state FETCH.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXE/MEM/WB/BR) driving IR/PC/RF/DM strobes, next-PC select and datapath field controls from state and op/funct
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       dm_rdy,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       rf_we,
  output logic       dm_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic [1:0] ext_op,
  output logic       illegal,
  output logic [2:0] state
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXE = 3'd2, MEM = 3'd3, WB = 3'd4, BR = 3'd5;
  logic [2:0] st, nst;
  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_ill, short_seq;
  logic act, in_instr, s_dec, s_mem;
  always_comb begin
    is_addu = op == 6'b000000 && funct == 6'b100001;
    is_subu = op == 6'b000000 && funct == 6'b100011;
    is_jr = op == 6'b000000 && funct == 6'b001000;
    is_ori = op == 6'b001101;
    is_lui = op == 6'b001111;
    is_lw = op == 6'b100011;
    is_sw = op == 6'b101011;
    is_beq = op == 6'b000100;
    is_j = op == 6'b000010;
    is_jal = op == 6'b000011;
    is_ill = !(is_addu || is_subu || is_jr || is_ori || is_lui || is_lw || is_sw || is_beq || is_j || is_jal);
    short_seq = is_j || is_jal || is_jr || is_ill;
    nst = st == FETCH ? DECODE :
          st == DECODE ? (short_seq ? FETCH : is_beq ? BR : EXE) :
          st == EXE ? ((is_lw || is_sw) ? MEM : WB) :
          st == MEM ? (!dm_rdy ? MEM : is_lw ? WB : FETCH) : FETCH;
  end
  always_ff @(posedge clk) st <= rst ? FETCH : nst;
  always_comb begin
    act = !rst;
    in_instr = act && st != FETCH && st <= BR;
    s_dec = act && st == DECODE;
    s_mem = act && st == MEM;
    state = act ? st : 3'd0;
    ir_we = act && st == FETCH;
    pc_we = (s_dec && short_seq) || (act && (st == BR || st == WB)) || (s_mem && is_sw && dm_rdy);
    npc_sel = !pc_we ? 2'b00 :
              (act && st == BR) ? 2'b01 :
              (s_dec && (is_j || is_jal)) ? 2'b10 :
              (s_dec && is_jr) ? 2'b11 : 2'b00;
    rf_we = (act && st == WB) || (s_dec && is_jal);
    dm_we = s_mem && is_sw;
    illegal = s_dec && is_ill;
    reg_dst = !in_instr ? 2'b00 : (is_addu || is_subu) ? 2'b01 : is_jal ? 2'b10 : 2'b00;
    wd_sel = !in_instr ? 2'b00 : is_lw ? 2'b01 : is_jal ? 2'b10 : 2'b00;
    alu_src = in_instr && (is_ori || is_lui || is_lw || is_sw);
    alu_op = !in_instr ? 2'b00 : (is_subu || is_beq) ? 2'b01 : is_ori ? 2'b10 : 2'b00;
    ext_op = !in_instr ? 2'b00 : (is_lw || is_sw) ? 2'b01 : is_lui ? 2'b10 : 2'b00;
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and random instruction streams checked cycle-by-cycle against a per-instruction sequence model
module tb_mc_ctrl;
  logic clk = 1'b0, rst = 1'b1, dm_rdy = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic ir_we, pc_we, rf_we, dm_we, alu_src, illegal;
  logic [1:0] npc_sel, reg_dst, wd_sel, alu_op, ext_op;
  logic [2:0] state;
  int n_cmp = 0, n_bad = 0;
  logic [8:0] fld [11] = '{9'b01_00_0_00_00, 9'b01_00_0_01_00, 9'b0, 9'b00_00_1_10_00, 9'b00_00_1_00_10,
                           9'b00_01_1_00_01, 9'b00_00_1_00_01, 9'b00_00_0_01_00, 9'b0, 9'b10_10_0_00_00, 9'b0};
  logic [18:0] obs;
  mc_ctrl dut (.clk(clk), .rst(rst), .op(op), .funct(funct), .dm_rdy(dm_rdy), .ir_we(ir_we), .pc_we(pc_we),
    .npc_sel(npc_sel), .rf_we(rf_we), .dm_we(dm_we), .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src),
    .alu_op(alu_op), .ext_op(ext_op), .illegal(illegal), .state(state));
  always #5 clk = ~clk;
  assign obs = {state, ir_we, pc_we, npc_sel, rf_we, dm_we, reg_dst, wd_sel, alu_src, alu_op, ext_op, illegal};
  function automatic logic supported(input logic [5:0] o, input logic [5:0] f);
    return (o == 6'd0 && (f == 6'b100001 || f == 6'b100011 || f == 6'b001000)) ||
           o inside {6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
  endfunction
  task automatic enc(input int k, output logic [5:0] o, output logic [5:0] f);
    f = 6'($urandom);
    o = 6'd0;
    case (k)
      0: f = 6'b100001;
      1: f = 6'b100011;
      2: f = 6'b001000;
      3: o = 6'b001101;
      4: o = 6'b001111;
      5: o = 6'b100011;
      6: o = 6'b101011;
      7: o = 6'b000100;
      8: o = 6'b000010;
      9: o = 6'b000011;
      default: do begin o = 6'($urandom); f = 6'($urandom); end while (supported(o, f));
    endcase
  endtask
  task automatic cyc(input string tag, input logic [18:0] exp);
    @(negedge clk);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic hold_rst(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      dm_rdy = 1'($urandom);
      cyc("reset", 19'd0);
    end
    rst = 1'b0;
  endtask
  // k: 0 addu 1 subu 2 jr 3 ori 4 lui 5 lw 6 sw 7 beq 8 j 9 jal 10 illegal
  task automatic run(input int k, input int stall, input int maxc, input logic [5:0] o, input logic [5:0] f);
    int sq[$];
    int n, s;
    logic last, rfw, dmw;
    logic [1:0] npc;
    logic [8:0] fl;
    op = o;
    funct = f;
    sq = '{0, 1};
    if (k inside {0, 1, 3, 4}) sq = '{0, 1, 2, 4};
    if (k == 7) sq = '{0, 1, 5};
    if (k == 5 || k == 6) begin
      sq = '{0, 1, 2};
      for (int i = 0; i <= stall; i++) sq.push_back(3);
      if (k == 5) sq.push_back(4);
    end
    n = sq.size();
    for (int i = 0; i < n && i < maxc; i++) begin
      s = sq[i];
      last = i == n - 1;
      dm_rdy = s == 3 ? (last || sq[i+1] != 3) : 1'($urandom);
      npc = !last ? 2'd0 : k == 7 ? 2'd1 : (k == 8 || k == 9) ? 2'd2 : k == 2 ? 2'd3 : 2'd0;
      rfw = last && k inside {0, 1, 3, 4, 5, 9};
      dmw = s == 3 && k == 6;
      fl = i > 0 ? fld[k] : 9'd0;
      cyc($sformatf("k%0d_c%0d", k, i), {3'(s), i == 0, last, npc, rfw, dmw, fl, last && k == 10});
    end
  endtask
  initial begin
    logic [5:0] o, f;
    int k;
    hold_rst(3);
    enc(0, o, f); run(0, 0, 99, o, f);
    enc(5, o, f); run(5, 2, 99, o, f);
    enc(6, o, f); run(6, 2, 99, o, f);
    enc(7, o, f); run(7, 0, 99, o, f);
    enc(9, o, f); run(9, 0, 99, o, f);
    enc(2, o, f); run(2, 0, 99, o, f);
    run(10, 0, 99, 6'h3f, 6'($urandom));
    enc(5, o, f); run(5, 2, 4, o, f);
    hold_rst(3);
    enc(5, o, f); run(5, 1, 99, o, f);
    for (int i = 0; i < 11; i++) begin
      enc(i, o, f);
      run(i, 0, 99, o, f);
    end
    for (int t = 0; t < 300; t++) begin
      k = $urandom_range(0, 10);
      enc(k, o, f);
      if ($urandom_range(0, 19) == 0) begin
        run(k, $urandom_range(0, 3), $urandom_range(1, 5), o, f);
        hold_rst($urandom_range(1, 3));
      end else run(k, $urandom_range(0, 3), 99, o, f);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
